// File: rtl/dc_mem_arbiter_pkg.sv
// Shared dcache arbiter types: FSM states, store-queue entry, memory request and block helper.
package dc_mem_arbiter_pkg;

    localparam int DCACHE_BLOCK_ADDR_BITS = 26;
    localparam int DCACHE_ST_ADDR_BITS    = 32;
    localparam int SIZE_DATA              = 32;
    localparam int BLOCK_OFFSET_BITS      = DCACHE_ST_ADDR_BITS - DCACHE_BLOCK_ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LD,
        ISSUE_ST,
        WAIT_ST,
        WAIT_LD
    } arbState_e;

    typedef struct packed {
        logic [DCACHE_ST_ADDR_BITS-1:0] addr;
        logic [SIZE_DATA-1:0]           data;
        logic [2:0]                     size;
    } stEntry_t;

    typedef struct packed {
        logic                           isSt;
        logic [DCACHE_ST_ADDR_BITS-1:0] addr;
        logic [SIZE_DATA-1:0]           data;
        logic [2:0]                     size;
        logic [1:0]                     way;
    } memReq_t;

    // Cache block number of a byte-granular store address.
    function automatic logic [DCACHE_BLOCK_ADDR_BITS-1:0] blockOf(
        input logic [DCACHE_ST_ADDR_BITS-1:0] addr
    );
        return addr[DCACHE_ST_ADDR_BITS-1:BLOCK_OFFSET_BITS];
    endfunction

endpackage

// File: rtl/dc_mem_arbiter_if.sv
// Cache-side and memory-side request bundle of the dcache memory arbiter.
interface dc_mem_arbiter_if;
    import dc_mem_arbiter_pkg::*;

    logic                              ldReqValid_i;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ldReqAddr_i;
    logic [1:0]                        ldReqWay_i;
    logic                              ldReqReady_o;

    logic                              stReqValid_i;
    logic [DCACHE_ST_ADDR_BITS-1:0]    stReqAddr_i;
    logic [SIZE_DATA-1:0]              stReqData_i;
    logic [2:0]                        stReqSize_i;
    logic                              stReqReady_o;

    logic                              memReqValid_o;
    logic                              memReqIsSt_o;
    logic [DCACHE_ST_ADDR_BITS-1:0]    memReqAddr_o;
    logic [SIZE_DATA-1:0]              memReqData_o;
    logic [2:0]                        memReqSize_o;
    logic [1:0]                        memReqWay_o;
    logic                              memReqReady_i;
    logic                              memStComplete_i;
    logic                              memLdFill_i;

    logic                              stallStCommit_o;
    logic                              stQEmpty_o;
    logic                              ldBusy_o;

    modport slave (
        input  ldReqValid_i, ldReqAddr_i, ldReqWay_i,
        input  stReqValid_i, stReqAddr_i, stReqData_i, stReqSize_i,
        input  memReqReady_i, memStComplete_i, memLdFill_i,
        output ldReqReady_o, stReqReady_o,
        output memReqValid_o, memReqIsSt_o, memReqAddr_o, memReqData_o, memReqSize_o, memReqWay_o,
        output stallStCommit_o, stQEmpty_o, ldBusy_o
    );

    modport master (
        output ldReqValid_i, ldReqAddr_i, ldReqWay_i,
        output stReqValid_i, stReqAddr_i, stReqData_i, stReqSize_i,
        output memReqReady_i, memStComplete_i, memLdFill_i,
        input  ldReqReady_o, stReqReady_o,
        input  memReqValid_o, memReqIsSt_o, memReqAddr_o, memReqData_o, memReqSize_o, memReqWay_o,
        input  stallStCommit_o, stQEmpty_o, ldBusy_o
    );

endinterface

// File: rtl/dc_st_fifo.sv
// In-order write-through store queue. With DC_ARB_RAW_CHECK_EN defined it also reports
// whether any queued store falls in a given cache block.
module dc_st_fifo
    import dc_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  stEntry_t pushData_i,
    input  logic     pop_i,
    output stEntry_t head_o,
    output logic     full_o,
    output logic     empty_o
`ifdef DC_ARB_RAW_CHECK_EN
    ,
    input  logic [DCACHE_BLOCK_ADDR_BITS-1:0] matchBlock_i,
    output logic                              match_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    stEntry_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

`ifdef DC_ARB_RAW_CHECK_EN
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (doPush) begin
                valid_q[wrPtr_q] <= 1'b1;
            end
            if (doPop) begin
                valid_q[rdPtr_q] <= 1'b0;
            end
        end
    end

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (blockOf(mem_q[i].addr) == matchBlock_i)) begin
                match_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dc_mem_arbiter.sv
// Arbitrates dcache load-miss block reads against queued write-through stores toward memory.
// Optional DC_ARB_RAW_CHECK_EN makes a load wait until every queued store to its block has issued.
module dc_mem_arbiter
    import dc_mem_arbiter_pkg::*;
#(
    parameter int ST_Q_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    dc_mem_arbiter_if.slave  bus
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    arbState_e                         state_q, state_d;
    memReq_t                           memReq_q, memReq_d;
    logic                              ldCapValid_q, ldCapValid_d;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ldCapAddr_q, ldCapAddr_d;
    logic [1:0]                        ldCapWay_q, ldCapWay_d;
    logic [STV_W-1:0]                  starve_q, starve_d;

    stEntry_t                          pushEntry;
    stEntry_t                          fifoHead;
    stEntry_t                          stHead;
    logic                              fifoFull;
    logic                              fifoEmpty;
    logic                              pushFire;
    logic                              popFire;
    logic                              ldReady;
    logic                              ldFire;
    logic                              ldPending;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ldAddr;
    logic [1:0]                        ldWay;
    logic                              storeAvail;
    logic                              rawHazard;

    assign pushEntry.addr = bus.stReqAddr_i;
    assign pushEntry.data = bus.stReqData_i;
    assign pushEntry.size = bus.stReqSize_i;

    assign pushFire   = bus.stReqValid_i && !fifoFull;
    assign popFire    = (state_q == ISSUE_ST) && bus.memReqReady_i;
    assign ldReady    = (state_q == IDLE) && !ldCapValid_q;
    assign ldFire     = bus.ldReqValid_i && ldReady;
    assign ldPending  = ldCapValid_q || ldFire;
    assign ldAddr     = ldCapValid_q ? ldCapAddr_q : bus.ldReqAddr_i;
    assign ldWay      = ldCapValid_q ? ldCapWay_q : bus.ldReqWay_i;

    // A store pushed into an empty queue is issued the same cycle it is accepted.
    assign storeAvail = !fifoEmpty || pushFire;
    assign stHead     = fifoEmpty ? pushEntry : fifoHead;

`ifdef DC_ARB_RAW_CHECK_EN
    logic fifoRawMatch;

    assign rawHazard = ldPending &&
                       (fifoRawMatch || (pushFire && (blockOf(bus.stReqAddr_i) == ldAddr)));
`else
    assign rawHazard = 1'b0;
`endif

    dc_st_fifo #(
        .DEPTH (ST_Q_DEPTH)
    ) uStFifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (pushFire),
        .pushData_i (pushEntry),
        .pop_i      (popFire),
        .head_o     (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
`ifdef DC_ARB_RAW_CHECK_EN
        ,
        .matchBlock_i (ldAddr),
        .match_o      (fifoRawMatch)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            memReq_q     <= '0;
            ldCapValid_q <= 1'b0;
            ldCapAddr_q  <= '0;
            ldCapWay_q   <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            memReq_q     <= memReq_d;
            ldCapValid_q <= ldCapValid_d;
            ldCapAddr_q  <= ldCapAddr_d;
            ldCapWay_q   <= ldCapWay_d;
            starve_q     <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        memReq_d     = memReq_q;
        ldCapValid_d = ldCapValid_q;
        ldCapAddr_d  = ldCapAddr_q;
        ldCapWay_d   = ldCapWay_q;
        starve_d     = starve_q;

        case (state_q)
            IDLE: begin
                if (storeAvail && (!ldPending || (starve_q == STV_MAX) || rawHazard)) begin
                    state_d       = ISSUE_ST;
                    memReq_d.isSt = 1'b1;
                    memReq_d.addr = stHead.addr;
                    memReq_d.data = stHead.data;
                    memReq_d.size = stHead.size;
                    memReq_d.way  = 2'b00;
                    starve_d      = '0;
                    if (ldFire) begin
                        ldCapValid_d = 1'b1;
                        ldCapAddr_d  = bus.ldReqAddr_i;
                        ldCapWay_d   = bus.ldReqWay_i;
                    end
                end else if (ldPending) begin
                    state_d       = ISSUE_LD;
                    memReq_d.isSt = 1'b0;
                    memReq_d.addr = DCACHE_ST_ADDR_BITS'(ldAddr);
                    memReq_d.data = '0;
                    memReq_d.size = '0;
                    memReq_d.way  = ldWay;
                    ldCapValid_d  = 1'b0;
                    if (!fifoEmpty && (starve_q != STV_MAX)) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end
            end
            ISSUE_LD: begin
                if (bus.memReqReady_i) begin
                    state_d = WAIT_LD;
                end
            end
            ISSUE_ST: begin
                if (bus.memReqReady_i) begin
                    state_d = WAIT_ST;
                end
            end
            WAIT_ST: begin
                if (bus.memStComplete_i) begin
                    state_d = IDLE;
                end
            end
            WAIT_LD: begin
                if (bus.memLdFill_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifoEmpty) begin
            starve_d = '0;
        end
    end

    assign bus.memReqValid_o   = (state_q == ISSUE_LD) || (state_q == ISSUE_ST);
    assign bus.memReqIsSt_o    = memReq_q.isSt;
    assign bus.memReqAddr_o    = memReq_q.addr;
    assign bus.memReqData_o    = memReq_q.data;
    assign bus.memReqSize_o    = memReq_q.size;
    assign bus.memReqWay_o     = memReq_q.way;
    assign bus.ldReqReady_o    = ldReady;
    assign bus.stReqReady_o    = !fifoFull;
    assign bus.stallStCommit_o = fifoFull;
    assign bus.stQEmpty_o      = fifoEmpty;
    assign bus.ldBusy_o        = ldCapValid_q || (state_q == ISSUE_LD) || (state_q == WAIT_LD);

endmodule

// File: tb/tb_dc_mem_arbiter.sv
// Directed self-checking bench for dc_mem_arbiter; expectations follow DC_ARB_RAW_CHECK_EN.
module tb_dc_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;
    int   loadGrants;

    dc_mem_arbiter_if bus ();

    dc_mem_arbiter #(
        .ST_Q_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] size);
        bus.stReqValid_i = valid;
        bus.stReqAddr_i  = addr;
        bus.stReqData_i  = data;
        bus.stReqSize_i  = size;
    endtask

    // Steps until a memory request is presented, bounded so a dead DUT still reaches the summary.
    task automatic waitRequest(input string tag);
        int n;
        n = 0;
        while (!bus.memReqValid_o && n < 30) begin
            stepClock();
            n++;
        end
        checkOutput({tag, "_req"}, bus.memReqValid_o, 1);
    endtask

    task automatic acceptAndFinish(input logic isStore);
        bus.memReqReady_i = 1'b1;
        stepClock();
        bus.memReqReady_i = 1'b0;
        if (isStore) bus.memStComplete_i = 1'b1;
        else         bus.memLdFill_i     = 1'b1;
        stepClock();
        bus.memStComplete_i = 1'b0;
        bus.memLdFill_i     = 1'b0;
    endtask

    task automatic serveStore(input string tag, input logic [31:0] addr, input logic [31:0] data);
        waitRequest(tag);
        checkOutput({tag, "_isSt"}, bus.memReqIsSt_o, 1);
        checkOutput({tag, "_addr"}, bus.memReqAddr_o, addr);
        checkOutput({tag, "_data"}, bus.memReqData_o, data);
        acceptAndFinish(1'b1);
    endtask

    task automatic serveLoad(input string tag, input logic [31:0] addr, input logic [1:0] way);
        waitRequest(tag);
        checkOutput({tag, "_isSt"}, bus.memReqIsSt_o, 0);
        checkOutput({tag, "_addr"}, bus.memReqAddr_o, addr);
        checkOutput({tag, "_way"}, bus.memReqWay_o, way);
        acceptAndFinish(1'b0);
    endtask

    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        bus.ldReqValid_i    = 1'b0;
        bus.ldReqAddr_i     = '0;
        bus.ldReqWay_i      = '0;
        bus.memReqReady_i   = 1'b0;
        bus.memStComplete_i = 1'b0;
        bus.memLdFill_i     = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_memValid", bus.memReqValid_o, 0);
        checkOutput("rst_stReady", bus.stReqReady_o, 1);
        checkOutput("rst_ldReady", bus.ldReqReady_o, 1);
        checkOutput("rst_stQEmpty", bus.stQEmpty_o, 1);
        checkOutput("rst_stall", bus.stallStCommit_o, 0);
        checkOutput("rst_ldBusy", bus.ldBusy_o, 0);
        checkOutput("rst_memAddr", bus.memReqAddr_o, 0);
        checkOutput("rst_isSt", bus.memReqIsSt_o, 0);

        $display("[TB] single store");
        applyStimulus(1'b1, 32'h100, 32'hDEAD, 3'd3);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        checkOutput("st1_valid", bus.memReqValid_o, 1);
        checkOutput("st1_isSt", bus.memReqIsSt_o, 1);
        checkOutput("st1_addr", bus.memReqAddr_o, 32'h100);
        checkOutput("st1_data", bus.memReqData_o, 32'hDEAD);
        checkOutput("st1_size", bus.memReqSize_o, 3);
        checkOutput("st1_notEmpty", bus.stQEmpty_o, 0);
        repeat (2) stepClock();
        checkOutput("st1_hold_valid", bus.memReqValid_o, 1);
        checkOutput("st1_hold_addr", bus.memReqAddr_o, 32'h100);
        bus.memReqReady_i = 1'b1;
        stepClock();
        bus.memReqReady_i = 1'b0;
        checkOutput("st1_waitValid", bus.memReqValid_o, 0);
        checkOutput("st1_popEmpty", bus.stQEmpty_o, 1);
        checkOutput("st1_waitLdReady", bus.ldReqReady_o, 0);
        bus.memLdFill_i = 1'b1;
        stepClock();
        bus.memLdFill_i = 1'b0;
        checkOutput("st1_strayFill", bus.ldReqReady_o, 0);
        bus.memStComplete_i = 1'b1;
        stepClock();
        bus.memStComplete_i = 1'b0;
        checkOutput("st1_idle", bus.ldReqReady_o, 1);

        $display("[TB] store queue fill");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h300 + 32'(k * 4), 32'h10 + 32'(k), 3'd2);
            if (k == 4) checkOutput("fill_stReadyFull", bus.stReqReady_o, 0);
            stepClock();
            if (k == 2) checkOutput("fill_stallAt3", bus.stallStCommit_o, 0);
            if (k == 3) checkOutput("fill_stallAt4", bus.stallStCommit_o, 1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        checkOutput("fill_stallHeld", bus.stallStCommit_o, 1);
        for (int k = 0; k < 4; k++) begin
            serveStore($sformatf("drain%0d", k), 32'h300 + 32'(k * 4), 32'h10 + 32'(k));
        end
        checkOutput("fill_emptyAfter", bus.stQEmpty_o, 1);
        repeat (3) stepClock();
        checkOutput("fill_noFifth", bus.memReqValid_o, 0);

        $display("[TB] starvation");
        bus.ldReqValid_i = 1'b1;
        bus.ldReqAddr_i  = 26'h123;
        bus.ldReqWay_i   = 2'd1;
        stepClock();
        checkOutput("ld0_valid", bus.memReqValid_o, 1);
        checkOutput("ld0_isSt", bus.memReqIsSt_o, 0);
        checkOutput("ld0_addr", bus.memReqAddr_o, 32'h123);
        checkOutput("ld0_way", bus.memReqWay_o, 1);
        checkOutput("ld0_busy", bus.ldBusy_o, 1);
        checkOutput("ld0_ldReady", bus.ldReqReady_o, 0);
        applyStimulus(1'b1, 32'h5000, 32'hA0, 3'd2);
        stepClock();
        applyStimulus(1'b1, 32'h5040, 32'hA1, 3'd2);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        acceptAndFinish(1'b0);
        loadGrants = 0;
        for (int k = 0; k < 12; k++) begin
            waitRequest("starve");
            if (bus.memReqIsSt_o) break;
            loadGrants++;
            acceptAndFinish(1'b0);
        end
        checkOutput("starve_loadGrants", 64'(loadGrants), 8);
        bus.ldReqValid_i = 1'b0;
        checkOutput("starve_capBusy", bus.ldBusy_o, 1);
        serveStore("starveSt0", 32'h5000, 32'hA0);
        serveLoad("starveCapLd", 32'h123, 2'd1);
        serveStore("starveSt1", 32'h5040, 32'hA1);
        checkOutput("starve_empty", bus.stQEmpty_o, 1);

        $display("[TB] same-block load behind queued store");
        applyStimulus(1'b1, 32'h2000, 32'hB0, 3'd2);
        stepClock();
        applyStimulus(1'b1, 32'h1000, 32'hB1, 3'd2);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        bus.ldReqValid_i = 1'b1;
        bus.ldReqAddr_i  = 26'h40;
        bus.ldReqWay_i   = 2'd2;
        serveStore("rawSa", 32'h2000, 32'hB0);
        stepClock();
        bus.ldReqValid_i = 1'b0;
`ifdef DC_ARB_RAW_CHECK_EN
        serveStore("rawSb", 32'h1000, 32'hB1);
        serveLoad("rawLd", 32'h40, 2'd2);
`else
        serveLoad("rawLd", 32'h40, 2'd2);
        serveStore("rawSb", 32'h1000, 32'hB1);
`endif

        $display("[TB] reset during load wait");
        bus.ldReqValid_i = 1'b1;
        bus.ldReqAddr_i  = 26'h77;
        bus.ldReqWay_i   = 2'd3;
        stepClock();
        bus.ldReqValid_i  = 1'b0;
        bus.memReqReady_i = 1'b1;
        stepClock();
        bus.memReqReady_i = 1'b0;
        applyStimulus(1'b1, 32'h900, 32'hC0, 3'd1);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        checkOutput("midRst_busyBefore", bus.ldBusy_o, 1);
        checkOutput("midRst_queued", bus.stQEmpty_o, 0);
        reset = 1'b1;
        #2;
        checkOutput("midRst_asyncBusy", bus.ldBusy_o, 0);
        checkOutput("midRst_asyncEmpty", bus.stQEmpty_o, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.memLdFill_i     = 1'b1;
        bus.memStComplete_i = 1'b1;
        stepClock();
        bus.memLdFill_i     = 1'b0;
        bus.memStComplete_i = 1'b0;
        checkOutput("midRst_valid", bus.memReqValid_o, 0);
        checkOutput("midRst_ldReady", bus.ldReqReady_o, 1);
        checkOutput("midRst_ldBusy", bus.ldBusy_o, 0);
        checkOutput("midRst_addr", bus.memReqAddr_o, 0);
        checkOutput("midRst_stReady", bus.stReqReady_o, 1);
        repeat (3) stepClock();
        checkOutput("midRst_quiet", bus.memReqValid_o, 0);
        applyStimulus(1'b1, 32'h440, 32'hD0, 3'd0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0);
        serveStore("postRst", 32'h440, 32'hD0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
